ecc_cmd_sequencer: RTL and testbench

Command sequencer for the ECC primitive engine. It queues a short program of primitive operations (square, reduce, swap, multiply, XOR, inverse) and their RAM start addresses from the host. On `run` it drives `command_ECC`/`start_addr` into the primitive engine one operation at a time, advancing only on the matching completion interrupt. It sits between the host/bus controller and the engine, so the host no longer polls the interrupt lines per operation.

---
 rtl/ecc_cmd_sequencer_if.sv | 23 ++
 rtl/ecc_cmd_sequencer.sv | 177 +++++++++++++++++
 tb/tb_ecc_cmd_sequencer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ecc_cmd_sequencer_if.sv
// Host-side push handshake into the ECC command sequencer queue.
// The host drives an entry; the sequencer reports space and occupancy.
interface ecc_cmd_sequencer_if #(
    parameter int DEPTH = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          push_valid;
    logic [3:0]    push_op;
    logic [2:0]    push_addr;
    logic          push_ready;
    logic [LW-1:0] level;

    modport master (
        output push_valid, push_op, push_addr,
        input  push_ready, level
    );

    modport slave (
        input  push_valid, push_op, push_addr,
        output push_ready, level
    );
endinterface

// File: rtl/ecc_cmd_sequencer.sv
// Queues primitive ECC operations from the host and feeds them to the engine
// one at a time, advancing on the matching completion interrupt.
module ecc_cmd_sequencer #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 4095
) (
    input  logic                clk,
    input  logic                rst,
    ecc_cmd_sequencer_if.slave  host,
    input  logic                run,
    input  logic                abort,
    input  logic                clear_err,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [3:0]          err_op,
    output logic [3:0]          command_ECC,
    output logic [2:0]          start_addr,
    input  logic                interupt_sqr,
    input  logic                interupt_red,
    input  logic                interupt_swap,
    input  logic                interupt_mul,
    input  logic                interupt_Xor,
    input  logic                interupt_inv
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = 12;
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GAP, S_ERR} state_t;

    state_t state, state_next;

    logic [6:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [LW-1:0] count;
    logic [CW-1:0] wait_cnt;
    logic [3:0]    pend_op;

    logic [3:0] head_op;
    logic [2:0] head_addr;
    logic       head_legal, head_nop, head_take;
    logic       irq_match, push_fire;

    logic       pop, issue, fire_done, flush, set_err, clr_cmd, cnt_inc, load_pend;
    logic [3:0] pend_in;

    assign head_op    = mem[rd_ptr][6:3];
    assign head_addr  = mem[rd_ptr][2:0];
    assign head_nop   = (head_op == 4'd0);
    assign head_legal = !head_nop && (head_op <= 4'd6);

    // Only the sequencer's own IDLE/GAP states ever look at the queue head.
    assign head_take = !abort && (count != '0) &&
                       (((state == S_IDLE) && run) || (state == S_GAP));

    assign host.push_ready = (count != LW'(DEPTH));
    assign host.level      = count;
    assign busy            = (state != S_IDLE);
    assign push_fire       = host.push_valid && host.push_ready && !flush;

    always_comb begin
        irq_match = 1'b0;
        case (command_ECC)
            4'd1:    irq_match = interupt_sqr;
            4'd2:    irq_match = interupt_red;
            4'd3:    irq_match = interupt_swap;
            4'd4:    irq_match = interupt_mul;
            4'd5:    irq_match = interupt_Xor;
            4'd6:    irq_match = interupt_inv;
            default: irq_match = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_GAP: begin
                    if (head_take) begin
                        if (head_legal)    state_next = S_WAIT;
                        else if (head_nop) state_next = S_GAP;
                        else               state_next = S_ERR;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (irq_match)                  state_next = S_GAP;
                    else if (wait_cnt == LAST_WAIT) state_next = S_ERR;
                end
                S_ERR:   state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // ERR needs the offending opcode one cycle later, so it is parked in pend_op.
    always_comb begin
        pop       = head_take;
        issue     = head_take && head_legal;
        fire_done = !abort && (count == '0) &&
                    (((state == S_IDLE) && run) || (state == S_GAP));
        flush     = abort || (state == S_ERR);
        set_err   = !abort && (state == S_ERR);
        clr_cmd   = flush || ((state == S_WAIT) && irq_match);
        cnt_inc   = !abort && (state == S_WAIT) && !irq_match;
        load_pend = 1'b0;
        pend_in   = pend_op;
        if (head_take && !head_legal && !head_nop) begin
            load_pend = 1'b1;
            pend_in   = head_op;
        end else if (!abort && (state == S_WAIT) && !irq_match && (wait_cnt == LAST_WAIT)) begin
            load_pend = 1'b1;
            pend_in   = command_ECC;
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire) mem[wr_ptr] <= {host.push_op, host.push_addr};
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire) wr_ptr <= wr_ptr + AW'(1);
            if (pop)       rd_ptr <= rd_ptr + AW'(1);
            case ({push_fire, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            command_ECC <= '0;
            start_addr  <= '0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_op      <= '0;
            wait_cnt    <= '0;
            pend_op     <= '0;
        end else begin
            done <= fire_done;
            if (clr_cmd) begin
                command_ECC <= '0;
            end else if (issue) begin
                command_ECC <= head_op;
                start_addr  <= head_addr;
            end
            if (issue)        wait_cnt <= '0;
            else if (cnt_inc) wait_cnt <= wait_cnt + CW'(1);
            if (load_pend) pend_op <= pend_in;
            // A new error outranks a clear requested in the same cycle.
            if (set_err) begin
                error  <= 1'b1;
                err_op <= pend_op;
            end else if (clear_err) begin
                error  <= 1'b0;
                err_op <= '0;
            end
        end
    end
endmodule

// File: tb/tb_ecc_cmd_sequencer.sv
// Scoreboard bench for ecc_cmd_sequencer: queued ops are expected back on
// command_ECC/start_addr in order, with an engine model answering each one.
`timescale 1ns/1ps
module tb_ecc_cmd_sequencer;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 4095;
    localparam int LW      = $clog2(DEPTH) + 1;

    logic       clk = 1'b0;
    logic       rst, run, abort, clear_err;
    logic       busy, done, error;
    logic [3:0] err_op, command_ECC;
    logic [2:0] start_addr;
    logic [5:0] irq;

    int tests_run    = 0;
    int tests_failed = 0;
    int done_seen    = 0;
    logic [6:0] exp_q [$];

    ecc_cmd_sequencer_if #(.DEPTH(DEPTH)) host ();

    ecc_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .host(host.slave),
        .run(run), .abort(abort), .clear_err(clear_err),
        .busy(busy), .done(done), .error(error), .err_op(err_op),
        .command_ECC(command_ECC), .start_addr(start_addr),
        .interupt_sqr(irq[0]), .interupt_red(irq[1]), .interupt_swap(irq[2]),
        .interupt_mul(irq[3]), .interupt_Xor(irq[4]), .interupt_inv(irq[5])
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_seen++;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time limit reached, tests_run=%0d", tests_run);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_entry(input logic [3:0] op, input logic [2:0] addr);
        host.push_valid = 1'b1;
        host.push_op    = op;
        host.push_addr  = addr;
        tick();
        host.push_valid = 1'b0;
    endtask

    task automatic test_reset();
        tests_run++; if (host.level !== 4'd0) begin tests_failed++; $display("[TB] FAIL reset_level: got %0d want 0", host.level); end
        tests_run++; if (host.push_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_push_ready: got %b want 1", host.push_ready); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done: got %b want 0", done); end
        tests_run++; if (error !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_error: got %b want 0", error); end
        tests_run++; if (err_op !== 4'd0) begin tests_failed++; $display("[TB] FAIL reset_err_op: got %0d want 0", err_op); end
        tests_run++; if (command_ECC !== 4'd0) begin tests_failed++; $display("[TB] FAIL reset_cmd: got %0d want 0", command_ECC); end
        tests_run++; if (start_addr !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_addr: got %0d want 0", start_addr); end
    endtask

    task automatic test_program();
        logic [3:0] ops [3];
        logic [2:0] adr [3];
        logic [6:0] e;
        int n, base;
        ops[0] = 4'd1; ops[1] = 4'd2; ops[2] = 4'd4;
        adr[0] = 3'd2; adr[1] = 3'd2; adr[2] = 3'd5;
        base = done_seen;
        for (int i = 0; i < 3; i++) begin
            push_entry(ops[i], adr[i]);
            exp_q.push_back({ops[i], adr[i]});
        end
        tests_run++; if (host.level !== 4'd3) begin tests_failed++; $display("[TB] FAIL prog_level_loaded: got %0d want 3", host.level); end
        run = 1'b1; tick(); run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (command_ECC === 4'd0 && n < 8) begin tick(); n++; end
            e = exp_q.pop_front();
            tests_run++; if (command_ECC !== e[6:3]) begin tests_failed++; $display("[TB] FAIL prog_cmd[%0d]: got %0d want %0d", i, command_ECC, e[6:3]); end
            tests_run++; if (start_addr !== e[2:0]) begin tests_failed++; $display("[TB] FAIL prog_addr[%0d]: got %0d want %0d", i, start_addr, e[2:0]); end
            tests_run++; if (host.level !== LW'(2 - i)) begin tests_failed++; $display("[TB] FAIL prog_level[%0d]: got %0d want %0d", i, host.level, 2 - i); end
            if (i > 0) begin
                tests_run++; if (n != 1) begin tests_failed++; $display("[TB] FAIL prog_gap_len[%0d]: got %0d want 1", i, n); end
            end
            repeat (9) tick();
            tests_run++; if (command_ECC !== e[6:3]) begin tests_failed++; $display("[TB] FAIL prog_hold[%0d]: got %0d want %0d", i, command_ECC, e[6:3]); end
            irq[e[6:3] - 4'd1] = 1'b1; tick(); irq = '0;
            tests_run++; if (command_ECC !== 4'd0) begin tests_failed++; $display("[TB] FAIL prog_gap_cmd[%0d]: got %0d want 0", i, command_ECC); end
            tests_run++; if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL prog_gap_done[%0d]: got %b want 0", i, done); end
        end
        tick();
        tests_run++; if (done !== 1'b1) begin tests_failed++; $display("[TB] FAIL prog_done: got %b want 1", done); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL prog_busy_end: got %b want 0", busy); end
        tests_run++; if (host.level !== 4'd0) begin tests_failed++; $display("[TB] FAIL prog_level_end: got %0d want 0", host.level); end
        tick();
        tests_run++; if (done_seen - base != 1) begin tests_failed++; $display("[TB] FAIL prog_done_count: got %0d want 1", done_seen - base); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] op;
        logic [2:0] ad;
        logic [6:0] e;
        int n, base, mlevel, pushes, pushed;
        base = done_seen;
        for (int k = 0; k < 9; k++) begin
            op = 4'((k % 6) + 1);
            ad = 3'(k % 8);
            tests_run++; if (host.push_ready !== 1'(k < 8)) begin tests_failed++; $display("[TB] FAIL full_ready[%0d]: got %b want %b", k, host.push_ready, k < 8); end
            if (k < 8) exp_q.push_back({op, ad});
            push_entry(op, ad);
        end
        tests_run++; if (host.level !== 4'd8) begin tests_failed++; $display("[TB] FAIL full_level: got %0d want 8", host.level); end
        run = 1'b1; tick(); run = 1'b0;
        mlevel = 7;
        pushes = 0;
        for (int j = 0; j < 20; j++) begin
            n = 0;
            while (command_ECC === 4'd0 && n < 8) begin tick(); n++; end
            e = exp_q.pop_front();
            tests_run++; if ({command_ECC, start_addr} !== e) begin tests_failed++; $display("[TB] FAIL wrap_cmd[%0d]: got %0d/%0d want %0d/%0d", j, command_ECC, start_addr, e[6:3], e[2:0]); end
            tests_run++; if (host.level !== LW'(mlevel)) begin tests_failed++; $display("[TB] FAIL wrap_level[%0d]: got %0d want %0d", j, host.level, mlevel); end
            tick(); tick();
            irq[e[6:3] - 4'd1] = 1'b1; tick(); irq = '0;
            pushed = 0;
            if (pushes < 12) begin
                op = 4'(((pushes + 9) % 6) + 1);
                ad = 3'((pushes + 9) % 8);
                host.push_valid = 1'b1; host.push_op = op; host.push_addr = ad;
                exp_q.push_back({op, ad});
                pushes++;
                pushed = 1;
            end
            tick();
            host.push_valid = 1'b0;
            if (mlevel > 0) mlevel = mlevel - 1 + pushed;
        end
        tests_run++; if (done !== 1'b1) begin tests_failed++; $display("[TB] FAIL wrap_done: got %b want 1", done); end
        tests_run++; if (host.level !== 4'd0) begin tests_failed++; $display("[TB] FAIL wrap_level_end: got %0d want 0", host.level); end
        tick();
        tests_run++; if (done_seen - base != 1) begin tests_failed++; $display("[TB] FAIL wrap_done_count: got %0d want 1", done_seen - base); end
    endtask

    task automatic test_timeout();
        int base, bad;
        base = done_seen;
        bad  = 0;
        push_entry(4'd4, 3'd3);
        push_entry(4'd1, 3'd1);
        push_entry(4'd2, 3'd2);
        run = 1'b1; tick(); run = 1'b0;
        tests_run++; if (command_ECC !== 4'd4) begin tests_failed++; $display("[TB] FAIL to_issue: got %0d want 4", command_ECC); end
        irq[0] = 1'b1; irq[1] = 1'b1;
        for (int c = 1; c < TIMEOUT; c++) begin
            tick();
            if (command_ECC !== 4'd4 || error !== 1'b0 || busy !== 1'b1) bad++;
        end
        tests_run++; if (bad != 0) begin tests_failed++; $display("[TB] FAIL to_hold: got %0d bad cycles want 0", bad); end
        tick();
        tests_run++; if (error !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL to_err_state: got error=%b busy=%b want 0/1", error, busy); end
        tick();
        irq = '0;
        tests_run++; if (error !== 1'b1) begin tests_failed++; $display("[TB] FAIL to_error: got %b want 1", error); end
        tests_run++; if (err_op !== 4'd4) begin tests_failed++; $display("[TB] FAIL to_err_op: got %0d want 4", err_op); end
        tests_run++; if (host.level !== 4'd0) begin tests_failed++; $display("[TB] FAIL to_level: got %0d want 0", host.level); end
        tests_run++; if (command_ECC !== 4'd0 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL to_idle: got cmd=%0d busy=%b want 0/0", command_ECC, busy); end
        tick();
        tests_run++; if (done_seen - base != 0) begin tests_failed++; $display("[TB] FAIL to_no_done: got %0d want 0", done_seen - base); end
        clear_err = 1'b1; tick(); clear_err = 1'b0;
        tests_run++; if (error !== 1'b0 || err_op !== 4'd0) begin tests_failed++; $display("[TB] FAIL to_clear: got %b/%0d want 0/0", error, err_op); end
    endtask

    task automatic test_illegal();
        int base, bad;
        base = done_seen;
        bad  = 0;
        push_entry(4'd0, 3'd1);
        push_entry(4'd7, 3'd2);
        push_entry(4'd5, 3'd3);
        run = 1'b1; tick(); run = 1'b0;
        if (command_ECC !== 4'd0) bad++;
        tick();
        if (command_ECC !== 4'd0) bad++;
        tick();
        tests_run++; if (error !== 1'b1) begin tests_failed++; $display("[TB] FAIL ill_error: got %b want 1", error); end
        tests_run++; if (err_op !== 4'd7) begin tests_failed++; $display("[TB] FAIL ill_err_op: got %0d want 7", err_op); end
        tests_run++; if (host.level !== 4'd0 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL ill_flush: got level=%0d busy=%b want 0/0", host.level, busy); end
        repeat (3) begin tick(); if (command_ECC !== 4'd0) bad++; end
        tests_run++; if (bad != 0) begin tests_failed++; $display("[TB] FAIL ill_no_issue: got %0d nonzero commands want 0", bad); end
        tests_run++; if (done_seen - base != 0) begin tests_failed++; $display("[TB] FAIL ill_no_done: got %0d want 0", done_seen - base); end
        clear_err = 1'b1; tick(); clear_err = 1'b0;
        tests_run++; if (error !== 1'b0 || err_op !== 4'd0) begin tests_failed++; $display("[TB] FAIL ill_clear: got %b/%0d want 0/0", error, err_op); end
    endtask

    task automatic test_run_empty();
        int base;
        base = done_seen;
        run = 1'b1; tick(); run = 1'b0;
        tests_run++; if (done !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL empty_done: got done=%b busy=%b want 1/0", done, busy); end
        tick();
        tests_run++; if (done_seen - base != 1) begin tests_failed++; $display("[TB] FAIL empty_done_count: got %0d want 1", done_seen - base); end
    endtask

    task automatic test_abort();
        int base;
        base = done_seen;
        for (int k = 0; k < 4; k++) push_entry(4'(k + 2), 3'(k + 4));
        run = 1'b1; tick(); run = 1'b0;
        repeat (3) tick();
        tests_run++; if (command_ECC !== 4'd2 || host.level !== 4'd3) begin tests_failed++; $display("[TB] FAIL abort_pre: got cmd=%0d level=%0d want 2/3", command_ECC, host.level); end
        abort = 1'b1; run = 1'b1; irq = '1;
        host.push_valid = 1'b1; host.push_op = 4'd3; host.push_addr = 3'd1;
        tick();
        abort = 1'b0; run = 1'b0; irq = '0; host.push_valid = 1'b0;
        tests_run++; if (command_ECC !== 4'd0) begin tests_failed++; $display("[TB] FAIL abort_cmd: got %0d want 0", command_ECC); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_busy: got %b want 0", busy); end
        tests_run++; if (host.level !== 4'd0) begin tests_failed++; $display("[TB] FAIL abort_level: got %0d want 0", host.level); end
        tests_run++; if (error !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_error: got %b want 0", error); end
        tick();
        tests_run++; if (done_seen - base != 0) begin tests_failed++; $display("[TB] FAIL abort_no_done: got %0d want 0", done_seen - base); end
    endtask

    task automatic test_rst();
        push_entry(4'd9, 3'd0);
        run = 1'b1; tick(); run = 1'b0;
        tick(); tick();
        tests_run++; if (error !== 1'b1 || err_op !== 4'd9) begin tests_failed++; $display("[TB] FAIL rst_pre_error: got %b/%0d want 1/9", error, err_op); end
        push_entry(4'd6, 3'd7);
        push_entry(4'd5, 3'd6);
        push_entry(4'd3, 3'd5);
        run = 1'b1; tick(); run = 1'b0;
        tests_run++; if (command_ECC !== 4'd6 || start_addr !== 3'd7) begin tests_failed++; $display("[TB] FAIL rst_pre_cmd: got %0d/%0d want 6/7", command_ECC, start_addr); end
        rst = 1'b1; run = 1'b1;
        host.push_valid = 1'b1; host.push_op = 4'd1; host.push_addr = 3'd1;
        tick();
        rst = 1'b0; run = 1'b0; host.push_valid = 1'b0;
        test_reset();
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; abort = 1'b0; clear_err = 1'b0; irq = '0;
        host.push_valid = 1'b0; host.push_op = '0; host.push_addr = '0;
        tick(); tick();
        rst = 1'b0;
        test_reset();
        test_program();
        test_back_to_back();
        test_timeout();
        test_illegal();
        test_run_empty();
        test_abort();
        test_rst();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
